load_pixel_tile: RTL and testbench

Parametrised successor to the fixed 4x4 pixel-block loader. Fetches a TILE_W x TILE_H tile of pixels from frame memory at tile coordinates (block_x, block_y), issuing one read per cycle. It absorbs a configurable memory read latency and presents the whole tile as one packed, atomically committed vector with a start/busy/done handshake. It sits between the frame buffer read port and the laser-path/feature-extraction logic.

---
 rtl/load_pixel_tile.sv | 173 +++++++++++++++++
 tb/tb_load_pixel_tile.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_pixel_tile.sv
// Loads a TILE_W x TILE_H pixel tile from frame memory and commits it as one packed vector (optional clamp: LOAD_PIXEL_TILE_CLAMP_EN).
// Latency: done is high in the cycle after edge N+MEM_LATENCY, counted from the edge that samples start (N = TILE_W*TILE_H).
// Backpressure: none; one read is issued per cycle, start is ignored while busy, and memory data must arrive exactly MEM_LATENCY cycles later.
module load_pixel_tile #(
    parameter int PIXEL_W     = 9,
    parameter int TILE_W      = 4,
    parameter int TILE_H      = 4,
    parameter int IDX_W       = 8,
    parameter int COORD_W     = 10,
    parameter int MEM_LATENCY = 2,
    parameter int FRAME_W     = 640,
    parameter int FRAME_H     = 480
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [IDX_W-1:0]                    block_x,
    input  logic [IDX_W-1:0]                    block_y,
    input  logic [PIXEL_W-1:0]                  mem_rdata,
    output logic [COORD_W-1:0]                  mem_hcount,
    output logic [COORD_W-1:0]                  mem_vcount,
    output logic                                mem_rd,
    output logic                                busy,
    output logic                                done,
    output logic [TILE_W*TILE_H*PIXEL_W-1:0]    tile_data
);

    localparam int N         = TILE_W * TILE_H;
    localparam int TILE_BITS = N * PIXEL_W;
    localparam int XW        = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int YW        = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int CW        = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       bx_q;
    logic [IDX_W-1:0]       by_q;
    logic [XW-1:0]          x_q;
    logic [YW-1:0]          y_q;
    logic [MEM_LATENCY-1:0] vld_pipe;
    logic [CW-1:0]          cap_idx;
    logic [TILE_BITS-1:0]   staging;
    logic [TILE_BITS-1:0]   staging_nxt;
    logic                   cap;
    logic                   last_cap;

    // Horizontal address: full-width product plus offset, optionally saturated
    // at the right frame edge, then wrapped to the address width.
    function automatic logic [COORD_W-1:0] addr_h(input logic [IDX_W-1:0] b,
                                                  input logic [XW-1:0]    o);
        logic [31:0] full;
        full = 32'(b) * 32'(TILE_W) + 32'(o);
`ifdef LOAD_PIXEL_TILE_CLAMP_EN
        if (full > 32'(FRAME_W - 1)) begin
            full = 32'(FRAME_W - 1);
        end
`endif
        return COORD_W'(full);
    endfunction

    // Vertical address: same scheme as the horizontal one, against the frame height.
    function automatic logic [COORD_W-1:0] addr_v(input logic [IDX_W-1:0] b,
                                                  input logic [YW-1:0]    o);
        logic [31:0] full;
        full = 32'(b) * 32'(TILE_H) + 32'(o);
`ifdef LOAD_PIXEL_TILE_CLAMP_EN
        if (full > 32'(FRAME_H - 1)) begin
            full = 32'(FRAME_H - 1);
        end
`endif
        return COORD_W'(full);
    endfunction

    // The oldest stage of the valid pipeline marks the cycle whose mem_rdata belongs to us.
    assign cap      = vld_pipe[MEM_LATENCY-1];
    assign last_cap = cap && (cap_idx == CW'(N - 1));

    // Staging image including this cycle's capture, so the final pixel can be
    // committed on the same edge it arrives.
    always_comb begin
        staging_nxt = staging;
        if (cap) begin
            staging_nxt[cap_idx*PIXEL_W +: PIXEL_W] = mem_rdata;
        end
    end

    // Track in-flight reads and fill the staging buffer in issue order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            cap_idx  <= '0;
            staging  <= '0;
        end else begin
            vld_pipe[0] <= mem_rd;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            staging <= staging_nxt;
            if (cap) begin
                cap_idx <= last_cap ? '0 : cap_idx + 1'b1;
            end
        end
    end

    // Load sequencer: latches coordinates, walks the tile in raster order with
    // registered addresses, then waits for the last capture and commits atomically.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bx_q       <= '0;
            by_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_hcount <= '0;
            mem_vcount <= '0;
            tile_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bx_q       <= block_x;
                        by_q       <= block_y;
                        x_q        <= '0;
                        y_q        <= '0;
                        busy       <= 1'b1;
                        mem_rd     <= 1'b1;
                        mem_hcount <= addr_h(block_x, '0);
                        mem_vcount <= addr_v(block_y, '0);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (x_q == XW'(TILE_W - 1)) begin
                        if (y_q == YW'(TILE_H - 1)) begin
                            // Last address is on the bus this cycle; stop issuing.
                            mem_rd <= 1'b0;
                            state  <= DRAIN;
                        end else begin
                            x_q        <= '0;
                            y_q        <= y_q + 1'b1;
                            mem_hcount <= addr_h(bx_q, '0);
                            mem_vcount <= addr_v(by_q, y_q + 1'b1);
                        end
                    end else begin
                        x_q        <= x_q + 1'b1;
                        mem_hcount <= addr_h(bx_q, x_q + 1'b1);
                    end
                end
                DRAIN: begin
                    if (last_cap) begin
                        tile_data <= staging_nxt;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_pixel_tile.sv
module tb_load_pixel_tile;

    logic         clk;
    logic         reset_n;

    // Default-configuration instance (4x4, latency 2)
    logic         start;
    logic [7:0]   block_x;
    logic [7:0]   block_y;
    logic [8:0]   mem_rdata;
    logic [9:0]   mem_hcount;
    logic [9:0]   mem_vcount;
    logic         mem_rd;
    logic         busy;
    logic         done;
    logic [143:0] tile_data;

    // Wide-tile instance (8x2, latency 3)
    logic         start_b;
    logic [7:0]   bx_b;
    logic [7:0]   by_b;
    logic [8:0]   rdata_b;
    logic [9:0]   hcount_b;
    logic [9:0]   vcount_b;
    logic         rd_b;
    logic         busy_b;
    logic         done_b;
    logic [143:0] tile_b;

    int checks = 0;
    int errors = 0;
    logic [143:0] prev_exp;

    load_pixel_tile dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .block_x    (block_x),
        .block_y    (block_y),
        .mem_rdata  (mem_rdata),
        .mem_hcount (mem_hcount),
        .mem_vcount (mem_vcount),
        .mem_rd     (mem_rd),
        .busy       (busy),
        .done       (done),
        .tile_data  (tile_data)
    );

    load_pixel_tile #(.TILE_W(8), .TILE_H(2), .MEM_LATENCY(3)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_b),
        .block_x    (bx_b),
        .block_y    (by_b),
        .mem_rdata  (rdata_b),
        .mem_hcount (hcount_b),
        .mem_vcount (vcount_b),
        .mem_rd     (rd_b),
        .busy       (busy_b),
        .done       (done_b),
        .tile_data  (tile_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] pix(input int h, input int v);
        return 9'((v * 640 + h) % 512);
    endfunction

    // Frame memory models: address sampled at a cycle's closing edge, data presented L cycles after the address cycle.
    logic [9:0] pa_h [2];
    logic [9:0] pa_v [2];
    logic [9:0] pb_h [3];
    logic [9:0] pb_v [3];
    always @(posedge clk) begin
        pa_h[0] <= mem_hcount; pa_v[0] <= mem_vcount;
        pa_h[1] <= pa_h[0];    pa_v[1] <= pa_v[0];
        pb_h[0] <= hcount_b;   pb_v[0] <= vcount_b;
        pb_h[1] <= pb_h[0];    pb_v[1] <= pb_v[0];
        pb_h[2] <= pb_h[1];    pb_v[2] <= pb_v[1];
    end
    assign mem_rdata = pix(int'(pa_h[1]), int'(pa_v[1]));
    assign rdata_b   = pix(int'(pb_h[2]), int'(pb_v[2]));

    function automatic int eh(input int bx, input int x, input int tw);
        int t;
        t = bx * tw + x;
`ifdef LOAD_PIXEL_TILE_CLAMP_EN
        if (t > 639) t = 639;
`endif
        return t % 1024;
    endfunction

    function automatic int ev(input int by, input int y, input int th);
        int t;
        t = by * th + y;
`ifdef LOAD_PIXEL_TILE_CLAMP_EN
        if (t > 479) t = 479;
`endif
        return t % 1024;
    endfunction

    function automatic logic [143:0] exp_tile(input int bx, input int by, input int tw, input int th);
        logic [143:0] r;
        r = '0;
        for (int y = 0; y < th; y++)
            for (int x = 0; x < tw; x++)
                r[(y*tw+x)*9 +: 9] = pix(eh(bx, x, tw), ev(by, y, th));
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int bx; int by;
        int h0; int h1; int v0; int v1;
        int p0; int p1;
    } vec_t;
    vec_t vecs[5];

    // One complete load on the default instance, checked against table entry i.
    task automatic run_vec(input int i, input bit poke);
        int rd, dn, lat;
        logic [9:0] h0, h1, v0, v1;
        logic bz;
        rd = 0; dn = 0; lat = -1; bz = 1'b1;
        h0 = '0; h1 = '0; v0 = '0; v1 = '0;
        @(negedge clk);
        start   = 1'b1;
        block_x = 8'(vecs[i].bx);
        block_y = 8'(vecs[i].by);
        @(posedge clk); #1;
        start   = 1'b0;
        block_x = 8'd77;
        block_y = 8'd66;
        for (int k = 0; k < 40; k++) begin
            if (mem_rd) begin
                if (rd == 0) begin h0 = mem_hcount; v0 = mem_vcount; end
                h1 = mem_hcount; v1 = mem_vcount;
                rd++;
            end
            if (done) begin
                dn++;
                if (lat < 0) begin lat = k; bz = busy; end
            end
            if (k == 17) check("tile_hold", tile_data, prev_exp);
            if (poke && (k == 3 || k == 10)) begin
                start = 1'b1; block_x = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("h_first",   h0, vecs[i].h0);
        check("h_last",    h1, vecs[i].h1);
        check("v_first",   v0, vecs[i].v0);
        check("v_last",    v1, vecs[i].v1);
        check("rd_cycles", rd, 16);
        check("done_lat",  lat, 18);
        check("done_cnt",  dn, 1);
        check("busy_done", bz, 1'b0);
        check("pix0",      tile_data[0 +: 9], vecs[i].p0);
        check("pix15",     tile_data[135 +: 9], vecs[i].p1);
        prev_exp = exp_tile(vecs[i].bx, vecs[i].by, 4, 4);
        check("tile",      tile_data, prev_exp);
    endtask

    initial begin
        int d1, d2, dc, rd, lat;
        logic [9:0] h0, h1, v0, v1;

        vecs[0] = '{bx: 3,   by: 2,   h0: 12,  h1: 15,  v0: 8,   v1: 11,  p0: 12,  p1: 399};
        vecs[1] = '{bx: 1,   by: 1,   h0: 4,   h1: 7,   v0: 4,   v1: 7,   p0: 4,   p1: 391};
        vecs[2] = '{bx: 0,   by: 0,   h0: 0,   h1: 3,   v0: 0,   v1: 3,   p0: 0,   p1: 387};
`ifdef LOAD_PIXEL_TILE_CLAMP_EN
        vecs[3] = '{bx: 255, by: 0,   h0: 639, h1: 639, v0: 0,   v1: 3,   p0: 127, p1: 511};
`else
        vecs[3] = '{bx: 255, by: 0,   h0: 1020, h1: 1023, v0: 0, v1: 3,   p0: 508, p1: 383};
`endif
        vecs[4] = '{bx: 10,  by: 119, h0: 40,  h1: 43,  v0: 476, v1: 479, p0: 40,  p1: 427};

        reset_n = 1'b0;
        start = 1'b0; block_x = '0; block_y = '0;
        start_b = 1'b0; bx_b = '0; by_b = '0;
        prev_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  busy, 1'b0);
        check("rst_done",  done, 1'b0);
        check("rst_rd",    mem_rd, 1'b0);
        check("rst_h",     mem_hcount, 10'd0);
        check("rst_v",     mem_vcount, 10'd0);
        check("rst_tile",  tile_data, 144'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven loads; entry 0 also gets start pokes mid-load
        for (int i = 0; i < 5; i++) run_vec(i, i == 0);

        // Reset in the middle of a load
        @(negedge clk);
        start = 1'b1; block_x = 8'd5; block_y = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd",   mem_rd, 1'b0);
        check("mid_rst_h",    mem_hcount, 10'd0);
        check("mid_rst_v",    mem_vcount, 10'd0);
        check("mid_rst_tile", tile_data, 144'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dc = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        check("mid_rst_nodone", dc, 0);
        prev_exp = '0;
        run_vec(1, 1'b0);

        // Back-to-back: start held high; second start is taken at the end of the done cycle
        d1 = -1; d2 = -1;
        @(negedge clk);
        start = 1'b1; block_x = 8'd2; block_y = 8'd3;
        @(posedge clk); #1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) begin d2 = k; start = 1'b0; end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("b2b_first",  d1, 18);
        check("b2b_second", d2, 18 + 1 + 18);
        check("b2b_tile",   tile_data, exp_tile(2, 3, 4, 4));
        check("b2b_idle",   busy, 1'b0);

        // Wide tile, longer latency
        rd = 0; lat = -1; dc = 0;
        h0 = '0; h1 = '0; v0 = '0; v1 = '0;
        @(negedge clk);
        start_b = 1'b1; bx_b = 8'd2; by_b = 8'd5;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rd_b) begin
                if (rd == 0) begin h0 = hcount_b; v0 = vcount_b; end
                h1 = hcount_b; v1 = vcount_b;
                rd++;
            end
            if (done_b) begin
                dc++;
                if (lat < 0) lat = k;
            end
            @(posedge clk); #1;
        end
        check("b_h_first", h0, 16);
        check("b_h_last",  h1, 23);
        check("b_v_first", v0, 10);
        check("b_v_last",  v1, 11);
        check("b_rd",      rd, 16);
        check("b_lat",     lat, 19);
        check("b_done",    dc, 1);
        check("b_pix0",    tile_b[0 +: 9], 272);
        check("b_pix15",   tile_b[135 +: 9], 407);
        check("b_tile",    tile_b, exp_tile(2, 5, 8, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
